// File: rtl/station_ctrl_if.sv
// Command and barcode handshake bundle between the receivers and station_ctrl.
// master = command receiver / barcode reader side, slave = station_ctrl.
interface station_ctrl_if;
  logic       cmd_rdy;
  logic [7:0] cmd;
  logic       clr_cmd_rdy;
  logic       ID_vld;
  logic [7:0] ID;
  logic       clr_ID_vld;

  modport master (
    output cmd_rdy, cmd, ID_vld, ID,
    input  clr_cmd_rdy, clr_ID_vld
  );

  modport slave (
    input  cmd_rdy, cmd, ID_vld, ID,
    output clr_cmd_rdy, clr_ID_vld
  );
endinterface

// File: rtl/station_ctrl.sv
// Go/stop command and destination-station sequencer for the line follower,
// with obstacle gating of motion and a piezo buzzer while blocked.
module station_ctrl #(
  parameter int BUZZ_DIV = 12500
) (
  input  logic           clk,
  input  logic           rst_n,
  station_ctrl_if.slave  bus,
  input  logic           i_OK2Move,
  output logic           o_in_transit,
  output logic           o_go,
  output logic [5:0]     o_dest_ID,
  output logic           o_buzz,
  output logic           o_buzz_n
);

  typedef enum logic {
    IDLE    = 1'b0,
    TRANSIT = 1'b1
  } state_t;

  localparam logic [14:0] LP_BUZZ_LAST = 15'(BUZZ_DIV - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [5:0]  r_destId;
  logic [5:0]  w_destNext;
  logic        w_clrCmd;
  logic        w_clrId;
  logic        w_inTransit;
  logic        w_buzzActive;
  logic [14:0] r_buzzCnt;
  logic        r_buzz;
  logic        w_unusedIdTop;

  // The barcode reader already qualifies ID[7:6].
  assign w_unusedIdTop = &{1'b0, bus.ID[7:6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_destId <= '0;
    end else begin
      r_state  <= w_nextState;
      r_destId <= w_destNext;
    end
  end

  // Commands win over IDs; a held ID is picked up the cycle after the command.
  always_comb begin
    w_nextState = r_state;
    w_destNext  = r_destId;
    w_clrCmd    = 1'b0;
    w_clrId     = 1'b0;
    if (rst_n) begin
      if (bus.cmd_rdy) begin
        w_clrCmd = 1'b1;
        case (bus.cmd[7:6])
          2'b01: begin
            w_nextState = TRANSIT;
            w_destNext  = bus.cmd[5:0];
          end
          2'b00:   w_nextState = IDLE;
          default: ;
        endcase
      end else if (bus.ID_vld) begin
        w_clrId = 1'b1;
        if ((r_state == TRANSIT) && (bus.ID[5:0] == r_destId)) begin
          w_nextState = IDLE;
        end
      end
    end
  end

  assign bus.clr_cmd_rdy = w_clrCmd;
  assign bus.clr_ID_vld  = w_clrId;

  assign w_inTransit  = (r_state == TRANSIT);
  assign o_in_transit = w_inTransit;
  assign o_go         = w_inTransit & i_OK2Move;
  assign o_dest_ID    = r_destId;

  assign w_buzzActive = w_inTransit & ~i_OK2Move;

  // Counter and tone phase sit at zero whenever the buzzer is idle, so each
  // activation starts with buzz_n high and the first buzz edge BUZZ_DIV later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buzzCnt <= '0;
      r_buzz    <= 1'b0;
    end else if (!w_buzzActive) begin
      r_buzzCnt <= '0;
      r_buzz    <= 1'b0;
    end else if (r_buzzCnt == LP_BUZZ_LAST) begin
      r_buzzCnt <= '0;
      r_buzz    <= ~r_buzz;
    end else begin
      r_buzzCnt <= r_buzzCnt + 15'd1;
    end
  end

  // Both legs low while idle so no DC sits across the piezo.
  assign o_buzz   = w_buzzActive & r_buzz;
  assign o_buzz_n = w_buzzActive & ~r_buzz;

endmodule

// File: tb/tb_station_ctrl.sv
// Scoreboard bench for station_ctrl: the driver predicts each acknowledge from
// a go/stop/arrival model, and a negedge monitor pops and compares as clears occur.
`timescale 1ns/1ps
module tb_station_ctrl;

  localparam int BUZZ_DIV = 4;

  typedef struct {
    logic       isCmd;
    logic       transit;
    logic [5:0] dest;
  } expT;

  logic       clk;
  logic       rst_n;
  logic       okToMove;
  logic       inTransit;
  logic       goOut;
  logic [5:0] destId;
  logic       buzz;
  logic       buzzN;

  station_ctrl_if sif ();

  station_ctrl #(.BUZZ_DIV(BUZZ_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (sif),
    .i_OK2Move    (okToMove),
    .o_in_transit (inTransit),
    .o_go         (goOut),
    .o_dest_ID    (destId),
    .o_buzz       (buzz),
    .o_buzz_n     (buzzN)
  );

  int  testsRun    = 0;
  int  testsFailed = 0;
  expT sbQ[$];

  // Reference model as seen by the driver, and the state the monitor expects now.
  logic       mTransit   = 1'b0;
  logic [5:0] mDest      = 6'd0;
  logic       curTransit = 1'b0;
  logic [5:0] curDest    = 6'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got no response, expected acknowledge at %0t", name, $time);
  endtask

  task automatic pushCmd(input logic [7:0] c);
    expT e;
    if (c[7:6] == 2'b01) begin
      mTransit = 1'b1;
      mDest    = c[5:0];
    end else if (c[7:6] == 2'b00) begin
      mTransit = 1'b0;
    end
    e.isCmd = 1'b1; e.transit = mTransit; e.dest = mDest;
    sbQ.push_back(e);
  endtask

  task automatic pushId(input logic [7:0] id);
    expT e;
    if (mTransit && (id[5:0] == mDest)) mTransit = 1'b0;
    e.isCmd = 1'b0; e.transit = mTransit; e.dest = mDest;
    sbQ.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that consumed the last valid.
  task automatic applyStimulus(input logic doCmd, input logic [7:0] c,
                               input logic doId, input logic [7:0] id,
                               output int nCmdClr, output int nIdClr);
    logic cmdPend, idPend, seenC, seenI;
    nCmdClr = 0;
    nIdClr  = 0;
    if (doCmd) pushCmd(c);
    if (doId)  pushId(id);
    cmdPend = doCmd;
    idPend  = doId;
    if (doCmd) begin sif.cmd = c;  sif.cmd_rdy = 1'b1; end
    if (doId)  begin sif.ID  = id; sif.ID_vld  = 1'b1; end
    for (int cyc = 0; cyc < 6 && (cmdPend || idPend); cyc++) begin
      @(negedge clk);
      seenC = sif.clr_cmd_rdy;
      seenI = sif.clr_ID_vld;
      if (seenC) nCmdClr++;
      if (seenI) nIdClr++;
      @(posedge clk);
      #1;
      if (seenC) begin sif.cmd_rdy = 1'b0; cmdPend = 1'b0; end
      if (seenI) begin sif.ID_vld  = 1'b0; idPend  = 1'b0; end
    end
    if (cmdPend || idPend) begin
      reportFail("ackTimeout");
      sif.cmd_rdy = 1'b0;
      sif.ID_vld  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    expT e;
    if (rst_n) begin
      checkOutput("inTransit", inTransit, curTransit);
      checkOutput("destId", destId, curDest);
      checkOutput("go", goOut, curTransit & okToMove);
      if (!(curTransit && !okToMove)) begin
        checkOutput("buzzIdle", buzz, 0);
        checkOutput("buzzNIdle", buzzN, 0);
      end
      if (sif.clr_cmd_rdy && sif.clr_ID_vld) checkOutput("bothClears", 1, 0);
      if (sif.clr_cmd_rdy || sif.clr_ID_vld) begin
        if (sbQ.size() == 0) begin
          checkOutput("spuriousClear", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("ackKind", sif.clr_cmd_rdy, e.isCmd);
          curTransit = e.transit;
          curDest    = e.dest;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nc, ni;
    logic [7:0] c, id;
    int kind;

    rst_n       = 1'b0;
    okToMove    = 1'b1;
    sif.cmd_rdy = 1'b1;
    sif.cmd     = 8'h45;
    sif.ID_vld  = 1'b1;
    sif.ID      = 8'h05;
    #12;
    checkOutput("rstClrCmd", sif.clr_cmd_rdy, 0);
    checkOutput("rstClrId", sif.clr_ID_vld, 0);
    checkOutput("rstTransit", inTransit, 0);
    checkOutput("rstGo", goOut, 0);
    checkOutput("rstDest", destId, 0);
    checkOutput("rstBuzz", {buzz, buzzN}, 0);
    sif.cmd_rdy = 1'b0;
    sif.ID_vld  = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Go then arrive
    applyStimulus(1, 8'h45, 0, 8'h00, nc, ni);
    checkOutput("goDest", destId, 5);
    checkOutput("goTransit", inTransit, 1);
    applyStimulus(0, 8'h00, 1, 8'h03, nc, ni);
    checkOutput("wrongStationTransit", inTransit, 1);
    applyStimulus(0, 8'h00, 1, 8'h05, nc, ni);
    checkOutput("arriveTransit", inTransit, 0);

    // Stop and reserved opcodes
    applyStimulus(1, 8'h45, 0, 8'h00, nc, ni);
    applyStimulus(1, 8'hC5, 0, 8'h00, nc, ni);
    checkOutput("reservedTransit", inTransit, 1);
    checkOutput("reservedDest", destId, 5);
    applyStimulus(1, 8'h00, 0, 8'h00, nc, ni);
    checkOutput("stopTransit", inTransit, 0);
    checkOutput("stopDestKept", destId, 5);

    // Redirect
    applyStimulus(1, 8'h45, 0, 8'h00, nc, ni);
    applyStimulus(1, 8'h49, 0, 8'h00, nc, ni);
    checkOutput("redirectDest", destId, 9);
    applyStimulus(0, 8'h00, 1, 8'h05, nc, ni);
    checkOutput("oldStationIgnored", inTransit, 1);
    applyStimulus(0, 8'h00, 1, 8'hC9, nc, ni);
    checkOutput("redirectArrive", inTransit, 0);

    // Simultaneous stop and matching ID
    applyStimulus(1, 8'h45, 0, 8'h00, nc, ni);
    applyStimulus(1, 8'h00, 1, 8'h05, nc, ni);
    checkOutput("simulCmdPulses", nc, 1);
    checkOutput("simulIdPulses", ni, 1);
    checkOutput("simulTransit", inTransit, 0);

    // Obstacle buzzer
    applyStimulus(1, 8'h45, 0, 8'h00, nc, ni);
    okToMove = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("obstacleGo", goOut, 0);
      checkOutput("buzzPhase", buzz, ((k / BUZZ_DIV) % 2) == 1);
      checkOutput("buzzNPhase", buzzN, ((k / BUZZ_DIV) % 2) == 0);
    end
    @(posedge clk); #1;
    okToMove = 1'b1;
    @(negedge clk);
    checkOutput("clearBuzz", {buzz, buzzN}, 0);
    checkOutput("clearGo", goOut, 1);
    @(posedge clk); #1;
    applyStimulus(1, 8'h00, 0, 8'h00, nc, ni);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind     = $urandom_range(3, 0);
      okToMove = ($urandom_range(4, 0) != 0);
      c  = {2'($urandom_range(3, 0)), 6'($urandom_range(15, 0))};
      id = {2'($urandom_range(3, 0)),
            ($urandom_range(1, 0) == 1) ? mDest : 6'($urandom_range(15, 0))};
      applyStimulus(kind != 2, c, kind >= 2, id, nc, ni);
      repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
    end
    okToMove = 1'b1;

    // Reset mid-transit with buzzer active
    applyStimulus(1, 8'h45, 0, 8'h00, nc, ni);
    okToMove = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    curTransit = 1'b0; curDest = 6'd0;
    mTransit   = 1'b0; mDest   = 6'd0;
    sbQ.delete();
    #1;
    checkOutput("midRstTransit", inTransit, 0);
    checkOutput("midRstGo", goOut, 0);
    checkOutput("midRstDest", destId, 0);
    checkOutput("midRstBuzz", buzz, 0);
    checkOutput("midRstBuzzN", buzzN, 0);
    #10;
    okToMove = 1'b1;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 8'h47, 0, 8'h00, nc, ni);
    checkOutput("postRstDest", destId, 7);

    repeat (3) @(posedge clk);
    checkOutput("queueEmpty", sbQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
